// File: rtl/project_led_pkg.sv
// Shared defaults and helpers for the LED PWM driver.
package project_led_pkg;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam int unsigned DEF_PRESCALE = 50;
  localparam int unsigned DEF_PWM_BITS = 4;

  // Terminal count of a PWM counter that is `bits` wide.
  function automatic int unsigned pwm_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/project_led_prescaler.sv
// Divides clk into PWM ticks: tick is high while the divider sits at PRESCALE-1.
module project_led_prescaler
  import project_led_pkg::*;
#(
  parameter int unsigned PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] r_pre_cnt;
  logic          r_run;
  logic          r_tick;

  // The first edge after reset is the shadow-load edge; counting begins one edge later.
  // tick is registered by looking one count ahead.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre_cnt <= '0;
      r_run     <= 1'b0;
      r_tick    <= 1'b0;
    end else if (!r_run) begin
      r_run <= 1'b1;
    end else begin
      if (r_pre_cnt == CW'(PRESCALE - 1)) begin
        r_pre_cnt <= '0;
      end else begin
        r_pre_cnt <= r_pre_cnt + CW'(1);
      end
      r_tick <= (r_pre_cnt == CW'(PRESCALE - 2));
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/project_led_pwm.sv
// PWM brightness driver for the PIO LED port; pattern and duty are shadowed at period boundaries.
// Optional blink gating is compiled in with `define LED_BLINK_EN.
module project_led_pwm
  import project_led_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned PRESCALE      = DEF_PRESCALE,
  parameter int unsigned PWM_BITS      = DEF_PWM_BITS
`ifdef LED_BLINK_EN
  ,
  parameter int unsigned BLINK_PERIODS = 8
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    led_in,
  input  logic [PWM_BITS-1:0] duty,
`ifdef LED_BLINK_EN
  input  logic [WIDTH-1:0]    blink_mask,
`endif
  output logic [WIDTH-1:0]    led_out,
  output logic                period_start
);

  localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(pwm_max(PWM_BITS));

  logic                w_tick;
  logic                w_boundary;
  logic                w_on;
  logic [WIDTH-1:0]    w_led_next;

  logic                r_init;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [WIDTH-1:0]    r_sh_led;
  logic [PWM_BITS-1:0] r_sh_duty;
  logic [WIDTH-1:0]    r_led_out;
  logic                r_period_start;

  project_led_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (w_tick)
  );

  assign w_boundary = w_tick && (r_pwm_cnt == MAX);
  assign w_on       = (r_sh_duty == MAX) || (r_pwm_cnt < r_sh_duty);

`ifdef LED_BLINK_EN
  localparam int unsigned BW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

  logic [WIDTH-1:0] r_sh_mask;
  logic [BW-1:0]    r_blink_cnt;
  logic             r_blink_phase;

  assign w_led_next = r_sh_led & {WIDTH{w_on}} & ~(r_sh_mask & {WIDTH{r_blink_phase}});

  // Mask shadows with the pattern; the period counter ignores the init load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh_mask     <= '0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_init) begin
      r_sh_mask <= blink_mask;
    end else if (w_boundary) begin
      r_sh_mask <= blink_mask;
      if (r_blink_cnt == BW'(BLINK_PERIODS - 1)) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BW'(1);
      end
    end
  end
`else
  assign w_led_next = r_sh_led & {WIDTH{w_on}};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_init         <= 1'b1;
      r_pwm_cnt      <= '0;
      r_sh_led       <= '0;
      r_sh_duty      <= '0;
      r_led_out      <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_led_out      <= w_led_next;
      r_period_start <= 1'b0;
      if (r_init) begin
        r_init         <= 1'b0;
        r_sh_led       <= led_in;
        r_sh_duty      <= duty;
        r_period_start <= 1'b1;
      end else if (w_boundary) begin
        r_pwm_cnt      <= '0;
        r_sh_led       <= led_in;
        r_sh_duty      <= duty;
        r_period_start <= 1'b1;
      end else if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      end
    end
  end

  assign led_out      = r_led_out;
  assign period_start = r_period_start;

endmodule

// File: tb/tb_project_led_pwm.sv
// Scoreboard bench for project_led_pwm: a time-based reference model queues expectations per edge.
module tb_project_led_pwm;

  localparam int unsigned W    = 8;
  localparam int unsigned P    = 4;
  localparam int unsigned PB   = 4;
  localparam int unsigned BP   = 2;
  localparam int          PER  = 64;
  localparam int          MAXV = 15;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] led_in;
  logic [PB-1:0] duty;
  logic [W-1:0] led_out;
  logic         period_start;
  logic [W-1:0] blink_mask;

  always #5 clk = ~clk;

  project_led_pwm #(
    .WIDTH         (W),
    .PRESCALE      (P),
    .PWM_BITS      (PB)
`ifdef LED_BLINK_EN
    ,
    .BLINK_PERIODS (BP)
`endif
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .led_in       (led_in),
    .duty         (duty),
`ifdef LED_BLINK_EN
    .blink_mask   (blink_mask),
`endif
    .led_out      (led_out),
    .period_start (period_start)
  );

  typedef struct packed {
    logic [W-1:0] led;
    logic         ps;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: t counts edges since reset release (t=0 is the load edge).
  int           t = -1;
  logic [W-1:0] m_led  = '0;
  logic [W-1:0] m_mask = '0;
  int           m_duty = 0;

  always @(posedge clk) begin : model
    exp_t e;
    int   pos;
    bit   on;
    e = '0;
    if (!reset_n) begin
      t      = -1;
      m_led  = '0;
      m_mask = '0;
      m_duty = 0;
    end else begin
      t = t + 1;
      if (t > 0) begin
        pos   = ((t - 1) / int'(P)) % 16;
        on    = (m_duty == MAXV) || (pos < m_duty);
        e.led = on ? m_led : '0;
`ifdef LED_BLINK_EN
        if ((((t - 1) / PER) / int'(BP)) % 2 == 1) e.led = e.led & ~m_mask;
`endif
      end
      e.ps = (t % PER == 0);
      if (t % PER == 0) begin
        m_led  = led_in;
        m_duty = int'(duty);
        m_mask = blink_mask;
      end
    end
    q.push_back(e);
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (!reset_n) e = '0;
      checks++;
      if (led_out !== e.led || period_start !== e.ps) begin
        errors++;
        $display("FAIL led_pwm t=%0d got led_out=%h period_start=%b want led_out=%h period_start=%b",
                 t, led_out, period_start, e.led, e.ps);
      end
    end
  end

  task automatic wait_ps();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 200);
    checks++;
    if (!period_start) begin
      errors++;
      $display("FAIL period_start_timeout got none within %0d clks want pulse", n);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    led_in     = 8'hA5;
    duty       = 4'd15;
    blink_mask = 8'h00;

    // Reset and init load.
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (2 * PER) @(negedge clk);

    // Dim.
    led_in = 8'hFF;
    duty   = 4'd4;
    repeat (2 * PER + 5) @(negedge clk);

    // Off.
    duty = 4'd0;
    repeat (2 * PER) @(negedge clk);

    // Glitch-free update mid-period.
    duty   = 4'd8;
    led_in = 8'h0F;
    wait_ps();
    wait_ps();
    repeat (20) @(negedge clk);
    led_in = 8'hF0;
    repeat (2 * PER) @(negedge clk);

    // Mid-period reset while fully on.
    led_in = 8'hFF;
    duty   = 4'd15;
    wait_ps();
    wait_ps();
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (led_out !== 8'h00 || period_start !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got led_out=%h period_start=%b want led_out=00 period_start=0",
               led_out, period_start);
    end
    led_in = 8'hA5;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2 * PER) @(negedge clk);

    // Blink gating (only meaningful when compiled in).
    blink_mask = 8'h01;
    led_in     = 8'h03;
    duty       = 4'd15;
    repeat (5 * PER) @(negedge clk);

    // Randomized: arbitrary-time changes and changes on the boundary edge itself.
    for (int i = 0; i < 30; i++) begin
      if (($urandom % 3) == 0) begin
        wait_ps();
        repeat (PER - 1) @(negedge clk);
      end else begin
        repeat ($urandom_range(1, 90)) @(negedge clk);
      end
      led_in     = W'($urandom);
      duty       = PB'($urandom);
      blink_mask = W'($urandom);
    end
    repeat (2 * PER) @(negedge clk);

    checks++;
    if (q.size() > 1) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want <=1", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/project_led_pwm.md
Name: project_led_pwm

Overview:
Downstream consumer of the LED PIO's 8-bit output port. It drives the physical LED pins with PWM brightness control. The PIO pattern and a brightness duty value are shadow-loaded only at PWM period boundaries, so software writes never glitch mid-period. It sits between the Avalon PIO slave and the board LED pins, in the same clock domain.

Parameters:
WIDTH, 8, number of LEDs; matches PIO port width
PRESCALE, 50, clk cycles per PWM tick; must be >= 2
PWM_BITS, 4, PWM counter width; 2^PWM_BITS ticks per period

Ports:
clk  in  1  system clock
reset_n  in  1  reset; asynchronous, active-low
led_in  in  WIDTH  LED pattern from PIO out_port
duty  in  PWM_BITS  brightness; 0 = off, all-ones = fully on
led_out  out  WIDTH  registered LED drive
period_start  out  1  one-clk pulse when new shadow values take effect

Behaviour:
- Reset (async, reset_n=0): pre_cnt=0, pwm_cnt=0, sh_led=0, sh_duty=0, init=1, led_out=0, period_start=0. Outputs go to 0 immediately on assertion, including mid-period.
- Prescaler: pre_cnt counts 0..PRESCALE-1 and wraps to 0. tick=1 while pre_cnt==PRESCALE-1.
- PWM counter: on tick, pwm_cnt increments and wraps from MAX=2^PWM_BITS-1 to 0. Period = PRESCALE*2^PWM_BITS clocks.
- Boundary event (tick && pwm_cnt==MAX) at an edge: pwm_cnt<=0, sh_led<=led_in, sh_duty<=duty, period_start<=1.
- First clock after reset release (init=1):
  - Loads sh_led/sh_duty and pulses period_start.
  - Clears init.
  - pre_cnt and pwm_cnt stay 0 on that edge.
  - Counting starts on the next edge.
- period_start is 0 on every other cycle.
- Output: on = (sh_duty==MAX) || (pwm_cnt < sh_duty). On each edge, led_out <= sh_led & {WIDTH{on}}, using pre-edge register values. led_out lags the counters by one clk.
- Duty levels: 0..MAX-1 give duty/2^PWM_BITS on-fraction; MAX gives 100%.
- Latency from a led_in/duty change to led_out: at most PRESCALE*2^PWM_BITS+1 clocks. It is exactly 1 clk after period_start is seen high.
- Inputs are sampled only at boundary edges. Changes between boundaries are ignored, including a change on the boundary edge itself (value present at that edge is used).
- led_in and duty are synchronous to clk; no CDC.

Optional Feature:
LED_BLINK_EN
- Defined:
  - Adds input blink_mask [WIDTH] and parameter BLINK_PERIODS (default 8).
  - blink_mask is shadowed with sh_led.
  - A period counter counts boundary events 0..BLINK_PERIODS-1. blink_phase toggles when it wraps.
  - While blink_phase=1, led_out bits with sh_mask set are forced 0.
  - Reset: counter=0, blink_phase=0. The init load does not count as a period.
- Undefined: no blink_mask port, no counter; behaviour exactly as above.

Decomposition:
- Package project_led_pkg: default WIDTH/PRESCALE/PWM_BITS constants, and a pwm_max(PWM_BITS) helper function.
- One sub-module, project_led_prescaler: parameter PRESCALE; ports clk, reset_n; output tick.
- Shadow registers, PWM compare, init flag and blink logic stay in project_led_pwm.

Test Plan:
All scenarios use PRESCALE=4, PWM_BITS=4, WIDTH=8 (period 64 clks).
- Reset/init: hold reset_n=0 with led_in=8'hA5, duty=15 -> led_out=0, period_start=0. Release -> period_start high on the first edge, led_out=8'hA5 from the second edge and constant.
- Dim: led_in=8'hFF, duty=4 -> each period led_out=8'hFF for 16 clks then 8'h00 for 48 clks; period_start every 64 clks.
- Off: duty=0, led_in=8'hFF -> led_out=8'h00 for the whole period after load.
- Glitch-free update:
  - Setup: duty=8, led_in=8'h0F.
  - Stimulus: change to 8'hF0 at clk 20 of a period.
  - Response: led_out keeps 8'h0F pattern until period_start, then shows 8'hF0 from the next clk.
- Mid-period reset: assert reset_n=0 at clk 10 while led_out=8'hFF -> led_out=8'h00 immediately. After release, init reload behaves as in the first scenario.
- LED_BLINK_EN with BLINK_PERIODS=2, blink_mask=8'h01, led_in=8'h03, duty=15 -> bit1 constantly on; bit0 on for 2 periods, off for 2 periods, repeating.
